// File: rtl/game_ctrl_fsm.sv
// Game control FSM for a side-scrolling bird game: collision detection against two pipes and the
// ground, pipe-pass scoring in saturating BCD, a timed HIT phase and a registered difficulty level.
`timescale 1ns/1ps
module game_ctrl_fsm #(
    parameter int BIRD_X     = 80,
    parameter int BIRD_W     = 40,
    parameter int BIRD_H     = 40,
    parameter int PIPE_W     = 60,
    parameter int GROUND_Y   = 400,
    parameter int HIT_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       restart,
    input  logic [9:0] bird_y,
    input  logic [9:0] pipe1_x,
    input  logic [9:0] pipe2_x,
    input  logic [9:0] gap1_top,
    input  logic [9:0] gap1_bot,
    input  logic [9:0] gap2_top,
    input  logic [9:0] gap2_bot,
    output logic [1:0] state,
    output logic       running,
    output logic       collision,
    output logic       gameover,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] level
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_e;

    localparam logic [10:0] HALF_H   = 11'(BIRD_H / 2);
    localparam logic [10:0] BIRD_L   = 11'(BIRD_X);
    localparam logic [10:0] BIRD_R   = 11'(BIRD_X + BIRD_W - 1);
    localparam logic [10:0] PW       = 11'(PIPE_W);
    localparam logic [10:0] PW_M1    = 11'(PIPE_W - 1);
    localparam logic [10:0] GROUND   = 11'(GROUND_Y);
    localparam logic [4:0]  HIT_LAST = 5'(HIT_FRAMES - 1);

    state_e      state_q, state_d;
    logic        passed1_q, passed1_d, passed2_q, passed2_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [11:0] score_q, score_d;
    logic [3:0]  level_q, level_d;

    logic [10:0] bird_top, bird_bot;
    logic        top_neg, ov1, ov2, hit, clr1, clr2;
    logic [1:0]  inc;

    // A negative top is flagged on its own, so the wrapped bird_top value never decides a hit.
    assign top_neg  = {1'b0, bird_y} < HALF_H;
    assign bird_top = {1'b0, bird_y} - HALF_H;
    assign bird_bot = {1'b0, bird_y} + HALF_H - 11'd1;

    assign ov1 = ({1'b0, pipe1_x} <= BIRD_R) && ({1'b0, pipe1_x} + PW_M1 >= BIRD_L);
    assign ov2 = ({1'b0, pipe2_x} <= BIRD_R) && ({1'b0, pipe2_x} + PW_M1 >= BIRD_L);

    assign hit = top_neg || (bird_bot >= GROUND)
              || (ov1 && ((bird_top < {1'b0, gap1_top}) || (bird_bot > {1'b0, gap1_bot})))
              || (ov2 && ((bird_top < {1'b0, gap2_top}) || (bird_bot > {1'b0, gap2_bot})));

    assign clr1 = ({1'b0, pipe1_x} + PW) <= BIRD_L;
    assign clr2 = ({1'b0, pipe2_x} + PW) <= BIRD_L;
    assign inc  = {1'b0, clr1 && !passed1_q} + {1'b0, clr2 && !passed2_q};

    function automatic logic [11:0] bcd_sat_add(input logic [11:0] s, input logic [1:0] add);
        logic [4:0] d0, d1, d2;
        d0 = {1'b0, s[3:0]} + {3'b000, add};
        d1 = {1'b0, s[7:4]};
        d2 = {1'b0, s[11:8]};
        if (d0 > 5'd9) begin
            d0 = d0 - 5'd10;
            d1 = d1 + 5'd1;
        end
        if (d1 > 5'd9) begin
            d1 = d1 - 5'd10;
            d2 = d2 + 5'd1;
        end
        if (d2 > 5'd9) return 12'h999;
        return {d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no latch can be inferred.
        state_d   = state_q;
        passed1_d = passed1_q;
        passed2_d = passed2_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        case (state_q)
            S_IDLE: if (flap) state_d = S_PLAY;
            S_PLAY: begin
                if (frame_tick) begin
                    if (hit) begin
                        state_d = S_HIT;
                        cnt_d   = '0;
                    end else begin
                        passed1_d = clr1;
                        passed2_d = clr2;
                        score_d   = bcd_sat_add(score_q, inc);
                    end
                end
            end
            S_HIT: begin
                if (frame_tick) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == HIT_LAST) state_d = S_OVER;
                end
            end
            default: ;
        endcase
        if (restart) begin
            state_d   = S_IDLE;
            passed1_d = 1'b0;
            passed2_d = 1'b0;
            cnt_d     = '0;
            score_d   = '0;
        end
    end

    // Level follows the registered tens digit, so it lags a score change by one cycle.
    always_comb begin
        level_d = 4'b0001;
        if (score_q[7:4] > 4'd4)      level_d = 4'b1111;
        else if (score_q[7:4] > 4'd2) level_d = 4'b0111;
        else if (score_q[7:4] > 4'd0) level_d = 4'b0011;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            passed1_q <= 1'b0;
            passed2_q <= 1'b0;
            cnt_q     <= '0;
            score_q   <= '0;
            level_q   <= 4'b0001;
        end else begin
            state_q   <= state_d;
            passed1_q <= passed1_d;
            passed2_q <= passed2_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            level_q   <= level_d;
        end
    end

    assign state     = state_q;
    assign running   = (state_q == S_PLAY);
    assign collision = (state_q == S_HIT) || (state_q == S_OVER);
    assign gameover  = (state_q == S_OVER);
    assign score0    = score_q[3:0];
    assign score1    = score_q[7:4];
    assign score2    = score_q[11:8];
    assign level     = level_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm: directed scenarios plus a randomized run compared
// against an integer-arithmetic model of the game rules.
`timescale 1ns/1ps
module tb_game_ctrl_fsm;

    localparam int BX = 80, BW = 40, BH = 40, PWD = 60, GY = 400, HF = 32;

    logic       clk, rst, frame_tick, flap, restart;
    logic [9:0] bird_y, pipe1_x, pipe2_x, gap1_top, gap1_bot, gap2_top, gap2_bot;
    logic [1:0] state;
    logic       running, collision, gameover;
    logic [3:0] score0, score1, score2, level;

    game_ctrl_fsm dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap(flap), .restart(restart),
        .bird_y(bird_y), .pipe1_x(pipe1_x), .pipe2_x(pipe2_x),
        .gap1_top(gap1_top), .gap1_bot(gap1_bot), .gap2_top(gap2_top), .gap2_bot(gap2_bot),
        .state(state), .running(running), .collision(collision), .gameover(gameover),
        .score0(score0), .score1(score1), .score2(score2), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, running, collision, gameover, hundreds, tens, ones, level}
    logic [20:0] obs;
    assign obs = {state, running, collision, gameover, score2, score1, score0, level};

    localparam logic [20:0] RESET_OBS = {2'd0, 3'b000, 12'h000, 4'b0001};

    int n_cmp = 0;
    int n_err = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic safe_field();
        bird_y = 10'd200;
        gap1_top = 10'd0;  gap1_bot = 10'd1023;
        gap2_top = 10'd0;  gap2_bot = 10'd1023;
        pipe1_x = 10'd600; pipe2_x = 10'd600;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_tick = 1'b0; flap = 1'b0; restart = 1'b0;
        safe_field();
        cyc(); cyc();
        n_cmp++;
        if (obs !== RESET_OBS) begin n_err++; $display("FAIL reset_state: got %h want %h", obs, RESET_OBS); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== RESET_OBS) begin n_err++; $display("FAIL idle_hold: got %h want %h", obs, RESET_OBS); end
    endtask

    task automatic test_start();
        flap = 1'b1;
        cyc();
        flap = 1'b0;
        n_cmp++;
        if (obs !== {2'd1, 3'b100, 12'h000, 4'b0001})
            begin n_err++; $display("FAIL start_play: got %h want %h", obs, {2'd1, 3'b100, 12'h000, 4'b0001}); end
    endtask

    task automatic test_score_pass();
        logic [11:0] want;
        bird_y = 10'd200; gap1_top = 10'd150; gap1_bot = 10'd260;
        gap2_top = 10'd0; gap2_bot = 10'd1023; pipe2_x = 10'd600;
        for (int x = 100; x >= 19; x--) begin
            pipe1_x = 10'(x);
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            want = (x <= 20) ? 12'h001 : 12'h000;
            n_cmp++;
            if ({state, score2, score1, score0} !== {2'd1, want})
                begin n_err++; $display("FAIL pass_x%0d: got %h want %h", x, {state, score2, score1, score0}, {2'd1, want}); end
            cyc();
        end
        n_cmp++;
        if (obs !== {2'd1, 3'b100, 12'h001, 4'b0001})
            begin n_err++; $display("FAIL pass_final: got %h want %h", obs, {2'd1, 3'b100, 12'h001, 4'b0001}); end
    endtask

    task automatic test_hit_over();
        pipe1_x = 10'd90; bird_y = 10'd120; gap1_top = 10'd150;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_cmp++;
        if (obs !== {2'd2, 3'b010, 12'h001, 4'b0001})
            begin n_err++; $display("FAIL hit_entry: got %h want %h", obs, {2'd2, 3'b010, 12'h001, 4'b0001}); end
        cyc();
        for (int i = 0; i < HF - 1; i++) tick();
        n_cmp++;
        if (obs !== {2'd2, 3'b010, 12'h001, 4'b0001})
            begin n_err++; $display("FAIL hit_31: got %h want %h", obs, {2'd2, 3'b010, 12'h001, 4'b0001}); end
        tick();
        n_cmp++;
        if (obs !== {2'd3, 3'b011, 12'h001, 4'b0001})
            begin n_err++; $display("FAIL over_32: got %h want %h", obs, {2'd3, 3'b011, 12'h001, 4'b0001}); end
        flap = 1'b1;
        cyc();
        flap = 1'b0;
        n_cmp++;
        if (obs !== {2'd3, 3'b011, 12'h001, 4'b0001})
            begin n_err++; $display("FAIL over_flap: got %h want %h", obs, {2'd3, 3'b011, 12'h001, 4'b0001}); end
    endtask

    task automatic test_restart_priority();
        flap = 1'b1; restart = 1'b1;
        cyc();
        flap = 1'b0; restart = 1'b0;
        n_cmp++;
        if (obs !== RESET_OBS) begin n_err++; $display("FAIL restart_flap: got %h want %h", obs, RESET_OBS); end
    endtask

    task automatic test_saturation();
        logic [3:0] want_lvl;
        safe_field();
        flap = 1'b1; cyc(); flap = 1'b0;
        for (int i = 0; i < 499; i++) begin
            pipe1_x = 10'd20; pipe2_x = 10'd20;
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            if (i == 4) begin
                n_cmp++;
                if ({score1, score0, level} !== {8'h10, 4'b0001})
                    begin n_err++; $display("FAIL level_lag: got %h want %h", {score1, score0, level}, {8'h10, 4'b0001}); end
            end
            cyc();
            pipe1_x = 10'd100; pipe2_x = 10'd100;
            tick();
            if (i == 4 || i == 14 || i == 24 || i == 49) begin
                want_lvl = (i == 4) ? 4'b0011 : (i == 14) ? 4'b0111 : (i == 24) ? 4'b1111 : 4'b0001;
                n_cmp++;
                if (level !== want_lvl)
                    begin n_err++; $display("FAIL level_at_%0d: got %b want %b", 2 * (i + 1), level, want_lvl); end
            end
        end
        n_cmp++;
        if (obs !== {2'd1, 3'b100, 12'h998, 4'b1111})
            begin n_err++; $display("FAIL score_998: got %h want %h", obs, {2'd1, 3'b100, 12'h998, 4'b1111}); end
        pipe1_x = 10'd20; pipe2_x = 10'd20;
        tick();
        n_cmp++;
        if (obs !== {2'd1, 3'b100, 12'h999, 4'b1111})
            begin n_err++; $display("FAIL score_sat: got %h want %h", obs, {2'd1, 3'b100, 12'h999, 4'b1111}); end
        pipe1_x = 10'd100; pipe2_x = 10'd100; tick();
        pipe1_x = 10'd20;  pipe2_x = 10'd20;  tick();
        n_cmp++;
        if (obs !== {2'd1, 3'b100, 12'h999, 4'b1111})
            begin n_err++; $display("FAIL score_hold999: got %h want %h", obs, {2'd1, 3'b100, 12'h999, 4'b1111}); end
    endtask

    task automatic test_ground_rst();
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++;
        if (obs !== RESET_OBS) begin n_err++; $display("FAIL rst_mid_play: got %h want %h", obs, RESET_OBS); end
        safe_field();
        flap = 1'b1; cyc(); flap = 1'b0;
        bird_y = 10'd380; tick();
        bird_y = 10'd20;  tick();
        n_cmp++;
        if (obs !== {2'd1, 3'b100, 12'h000, 4'b0001})
            begin n_err++; $display("FAIL edge_no_hit: got %h want %h", obs, {2'd1, 3'b100, 12'h000, 4'b0001}); end
        bird_y = 10'd385; tick();
        n_cmp++;
        if (obs !== {2'd2, 3'b010, 12'h000, 4'b0001})
            begin n_err++; $display("FAIL ground_hit: got %h want %h", obs, {2'd2, 3'b010, 12'h000, 4'b0001}); end
        tick(); tick(); tick();
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++;
        if (obs !== RESET_OBS) begin n_err++; $display("FAIL rst_mid_hit: got %h want %h", obs, RESET_OBS); end
        flap = 1'b1; cyc(); flap = 1'b0;
        bird_y = 10'd381; tick();
        for (int i = 0; i < HF - 1; i++) tick();
        n_cmp++;
        if (state !== 2'd2) begin n_err++; $display("FAIL cnt_cleared: got %0d want %0d", state, 2); end
        tick();
        n_cmp++;
        if (state !== 2'd3) begin n_err++; $display("FAIL cnt_over: got %0d want %0d", state, 3); end
        restart = 1'b1; cyc(); restart = 1'b0;
        flap = 1'b1; cyc(); flap = 1'b0;
        bird_y = 10'd19; tick();
        n_cmp++;
        if (state !== 2'd2) begin n_err++; $display("FAIL top_neg_hit: got %0d want %0d", state, 2); end
    endtask

    // Reference model: game rules expressed with signed integers on the spec geometry.
    int m_state, m_score, m_cnt;
    bit m_p1, m_p2;
    logic [3:0] m_level;

    function automatic logic [3:0] lvl_of(input int tens);
        if (tens > 4) return 4'b1111;
        if (tens > 2) return 4'b0111;
        if (tens > 0) return 4'b0011;
        return 4'b0001;
    endfunction

    function automatic bit pipe_blocks(input int px, input int gt, input int gb, input int top, input int bot);
        bit ov;
        ov = (px <= BX + BW - 1) && (px + PWD - 1 >= BX);
        return ov && (top < gt || bot > gb);
    endfunction

    task automatic model_edge();
        int top, bot, add;
        bit hit, c1, c2;
        logic [3:0] nl;
        nl  = lvl_of((m_score / 10) % 10);
        top = int'(bird_y) - BH / 2;
        bot = int'(bird_y) + BH / 2 - 1;
        hit = (top < 0) || (bot >= GY)
           || pipe_blocks(int'(pipe1_x), int'(gap1_top), int'(gap1_bot), top, bot)
           || pipe_blocks(int'(pipe2_x), int'(gap2_top), int'(gap2_bot), top, bot);
        c1 = (int'(pipe1_x) + PWD <= BX);
        c2 = (int'(pipe2_x) + PWD <= BX);
        if (rst) begin
            m_state = 0; m_score = 0; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_level = 4'b0001;
        end else begin
            m_level = nl;
            if (restart) begin
                m_state = 0; m_score = 0; m_cnt = 0; m_p1 = 0; m_p2 = 0;
            end else if (m_state == 0) begin
                if (flap) m_state = 1;
            end else if (m_state == 1) begin
                if (frame_tick) begin
                    if (hit) begin
                        m_state = 2; m_cnt = 0;
                    end else begin
                        add = int'(c1 && !m_p1) + int'(c2 && !m_p2);
                        m_score = (m_score + add > 999) ? 999 : m_score + add;
                        m_p1 = c1; m_p2 = c2;
                    end
                end
            end else if (m_state == 2) begin
                if (frame_tick) begin
                    m_cnt++;
                    if (m_cnt == HF) m_state = 3;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [20:0] want;
        rst = 1'b1; restart = 1'b0; flap = 1'b0; frame_tick = 1'b0;
        @(posedge clk); model_edge(); #1;
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            frame_tick = ($urandom_range(0, 1) == 0);
            flap       = ($urandom_range(0, 7) == 0);
            restart    = ($urandom_range(0, 79) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            bird_y     = 10'($urandom_range(10, 400));
            pipe1_x    = 10'($urandom_range(0, 300));
            pipe2_x    = 10'($urandom_range(0, 300));
            gap1_top   = 10'($urandom_range(0, 200));
            gap1_bot   = 10'(int'(gap1_top) + $urandom_range(100, 400));
            gap2_top   = 10'($urandom_range(0, 200));
            gap2_bot   = 10'(int'(gap2_top) + $urandom_range(100, 400));
            @(posedge clk);
            model_edge();
            #1;
            want = {2'(m_state), m_state == 1, m_state >= 2, m_state == 3,
                    4'(m_score / 100), 4'((m_score / 10) % 10), 4'(m_score % 10), m_level};
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL random_cyc%0d: got %h want %h", n, obs, want); end
        end
        rst = 1'b0; restart = 1'b0; flap = 1'b0; frame_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_score_pass();
        test_hit_over();
        test_restart_priority();
        test_saturation();
        test_ground_rst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
